// File: rtl/simon_pkg.sv
// Shared types, constants and bit helpers for the SIMON32/64 decrypt slice.
package simon_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned MAX_ROUNDS = 32;
  localparam int unsigned Z0_LEN     = 62;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPAND  = 2'd1,
    DECRYPT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // z0 sequence written left to right; the leftmost digit is z0[0]
  localparam logic [Z0_LEN-1:0] Z0_SEQ =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  localparam word_t C_KEY = 16'hFFFC;

  // j-th bit of z0, counted from the left end of Z0_SEQ
  function automatic logic z0_bit(input logic [5:0] j);
    return Z0_SEQ[6'(6'd61 - j)];
  endfunction

  function automatic word_t rotl(input word_t x, input int unsigned s);
    return word_t'((x << s) | (x >> (WORD_W - s)));
  endfunction

  function automatic word_t rotr(input word_t x, input int unsigned s);
    return word_t'((x >> s) | (x << (WORD_W - s)));
  endfunction

endpackage

// File: rtl/round.sv
// Single SIMON32/64 decrypt round: {x,y} -> {y, x ^ f(y) ^ k}.
module round
  import simon_pkg::*;
(
  input  logic [31:0] blk_in,
  input  logic [15:0] rkey,
  output logic [31:0] blk_out_c
);

  word_t x_c;
  word_t y_c;
  word_t f_c;

  // Inverse of the Feistel step; f(y) = (rotl1 & rotl8) ^ rotl2
  always_comb begin
    x_c       = blk_in[31:16];
    y_c       = blk_in[15:0];
    f_c       = (rotl(y_c, 1) & rotl(y_c, 8)) ^ rotl(y_c, 2);
    blk_out_c = {y_c, x_c ^ f_c ^ rkey};
  end

endmodule

// File: rtl/simon_key_step.sv
// One combinational SIMON32/64 key-expansion step: k[i], k[i+1], k[i+3], z -> k[i+4].
module simon_key_step
  import simon_pkg::*;
(
  input  logic [15:0] k_i,
  input  logic [15:0] k_i1,
  input  logic [15:0] k_i3,
  input  logic        z,
  output logic [15:0] k_next_c
);

  word_t t_c;

  // k[i+4] = C ^ z ^ k[i] ^ t ^ rotr1(t), t = rotr3(k[i+3]) ^ k[i+1]
  always_comb begin
    t_c      = rotr(k_i3, 3) ^ k_i1;
    k_next_c = C_KEY ^ {15'd0, z} ^ k_i ^ t_c ^ rotr(t_c, 1);
  end

endmodule

// File: rtl/simon_decrypt_ctrl.sv
// Iterative SIMON32/64 decrypt controller: expands round keys into a local
// buffer, then runs one decrypt round per cycle from k[ROUNDS-1] down to k[0].
// Optional macro SIMON_DEC_KEY_REUSE_EN adds key_reuse to skip expansion when
// the buffer already holds a complete schedule.
module simon_decrypt_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_key,
  input  logic [31:0] in_ct,
`ifdef SIMON_DEC_KEY_REUSE_EN
  input  logic        key_reuse,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pt,
  output logic        busy
);

  localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

  if ((ROUNDS < 5) || (ROUNDS > MAX_ROUNDS)) begin : g_bad_rounds
    $error("simon_decrypt_ctrl: ROUNDS must be within 5..32");
  end

  state_t      state_q, state_d;
  logic [31:0] blk_q, blk_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  rnd_q, rnd_d;
  logic        sched_ok_q, sched_ok_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  word_t       kbuf_q [MAX_ROUNDS];
  word_t       kbuf_d [MAX_ROUNDS];

  logic        reuse_c;
  word_t       key_next_c;
  logic [31:0] round_out_c;

`ifdef SIMON_DEC_KEY_REUSE_EN
  assign reuse_c = key_reuse & sched_ok_q;
`else
  assign reuse_c = 1'b0;
`endif

  simon_key_step u_key_step (
    .k_i      (kbuf_q[5'(idx_q - 5'd4)]),
    .k_i1     (kbuf_q[5'(idx_q - 5'd3)]),
    .k_i3     (kbuf_q[5'(idx_q - 5'd1)]),
    .z        (z0_bit(6'({1'b0, idx_q} - 6'd4))),
    .k_next_c (key_next_c)
  );

  round u_round (
    .blk_in    (blk_q),
    .rkey      (kbuf_q[rnd_q]),
    .blk_out_c (round_out_c)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    idx_d      = idx_q;
    rnd_d      = rnd_q;
    sched_ok_d = sched_ok_q;
    kbuf_d     = kbuf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          blk_d = in_ct;
          if (reuse_c) begin
            rnd_d   = LAST_IDX;
            state_d = DECRYPT;
          end else begin
            kbuf_d[0]  = in_key[15:0];
            kbuf_d[1]  = in_key[31:16];
            kbuf_d[2]  = in_key[47:32];
            kbuf_d[3]  = in_key[63:48];
            idx_d      = 5'd4;
            sched_ok_d = 1'b0;
            state_d    = EXPAND;
          end
        end
      end
      EXPAND: begin
        kbuf_d[idx_q] = key_next_c;
        if (idx_q == LAST_IDX) begin
          rnd_d   = LAST_IDX;
          state_d = DECRYPT;
        end else begin
          idx_d = 5'(idx_q + 5'd1);
        end
      end
      DECRYPT: begin
        blk_d = round_out_c;
        if (rnd_q == 5'd0) begin
          sched_ok_d = 1'b1;
          state_d    = DONE;
        end else begin
          rnd_d = 5'(rnd_q - 5'd1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == EXPAND) || (state_d == DECRYPT);
  end

  // Control and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      idx_q       <= '0;
      rnd_q       <= '0;
      sched_ok_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      idx_q       <= idx_d;
      rnd_q       <= rnd_d;
      sched_ok_q  <= sched_ok_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Round-key buffer keeps its contents across reset
  always_ff @(posedge clk) begin
    kbuf_q <= kbuf_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_pt    = blk_q;

endmodule

// File: tb/tb_simon_decrypt_ctrl.sv
// Directed bench for simon_decrypt_ctrl using the SIMON32/64 reference vector.
module tb_simon_decrypt_ctrl;

  localparam logic [63:0] KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] CT  = 32'hC69B_E9BB;
  localparam logic [31:0] PT  = 32'h6565_6877;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_key;
  logic [31:0] in_ct;
  logic        key_reuse;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simon_decrypt_ctrl #(.ROUNDS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .in_ct     (in_ct),
`ifdef SIMON_DEC_KEY_REUSE_EN
    .key_reuse (key_reuse),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pt    (out_pt),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_out_pt"},    out_pt,         32'd0);
  endtask

  // Accept at the next edge (E0); on return the bench sits just after E0
  task automatic accept(input logic [63:0] k, input logic [31:0] c, input logic reuse);
    in_valid  = 1'b1;
    in_key    = k;
    in_ct     = c;
    key_reuse = reuse;
    tick();
    in_valid  = 1'b0;
    key_reuse = 1'b0;
  endtask

  // From just after E0, confirm out_valid rises exactly at edge E(lat)
  task automatic expect_result(input string tag, input int lat);
    repeat (lat - 1) tick();
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pt"},    out_pt,         PT);
    check({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_key    = '0;
    in_ct     = '0;
    key_reuse = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // 1: reset state, reference vector, exact latency
    check_reset_outputs("reset");
    accept(KEY, CT, 1'b0);
    check("t1_busy_after_accept", 32'(busy),     32'd1);
    check("t1_in_ready_low",      32'(in_ready), 32'd0);
    expect_result("t1", 60);

    // 3: output held while out_ready is low
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_valid_hold", 32'(out_valid), 32'd1);
      check("t3_pt_hold",    out_pt,         PT);
      check("t3_in_ready",   32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("t3_valid_drop",  32'(out_valid), 32'd0);
    check("t3_ready_back",  32'(in_ready),  32'd1);

    // 2: back-to-back with in_valid held high and out_ready high
    in_valid = 1'b1;
    in_key   = KEY;
    in_ct    = CT;
    tick();
    check("t2a_busy", 32'(busy), 32'd1);
    expect_result("t2a", 60);
    tick();
    check("t2_handshake_valid", 32'(out_valid), 32'd0);
    check("t2_handshake_ready", 32'(in_ready),  32'd1);
    tick();
    check("t2b_accept_busy",  32'(busy),     32'd1);
    check("t2b_accept_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    expect_result("t2b", 60);
    tick();
    check("t2b_ready_back", 32'(in_ready), 32'd1);

    // 5: in_valid toggled with junk while busy must be ignored
    accept(KEY, CT, 1'b0);
    for (int i = 1; i < 60; i++) begin
      in_valid = (i % 2) == 1;
      in_key   = {$urandom, $urandom};
      in_ct    = $urandom;
      tick();
      if (i % 20 == 0) check("t5_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("t5_early", 32'(out_valid), 32'd0);
    tick();
    check("t5_valid", 32'(out_valid), 32'd1);
    check("t5_pt",    out_pt,         PT);
    tick();
    check("t5_ready_back", 32'(in_ready), 32'd1);

    // 4: reset at E20 aborts, then a fresh request completes
    accept(KEY, CT, 1'b0);
    repeat (19) tick();
    check("t4_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("t4_after_rst");
    tick();
    check("t4_no_partial_valid", 32'(out_valid), 32'd0);
    accept(KEY, CT, 1'b0);
    expect_result("t4", 60);
    tick();
    check("t4_ready_back", 32'(in_ready), 32'd1);

`ifdef SIMON_DEC_KEY_REUSE_EN
    // 6: reuse of a complete schedule skips expansion
    accept(32'hDEAD_BEEF, CT, 1'b1);
    expect_result("t6_reuse", 32);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("t6_after_rst");
    accept(KEY, CT, 1'b1);
    expect_result("t6_after_rst_full", 60);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
